spi_req_arbiter: RTL and testbench



---
 rtl/spi_arb_pkg.sv | 17 +
 rtl/rr_picker.sv | 31 +++
 rtl/spi_req_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and sizing helpers for the SPI request arbiter.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_GAP    = 2'd2
   } arb_state_t;

   // Wide enough for any TIMEOUT_CYCLES override without revisiting the counter.
   localparam int TO_CNT_W = 32;

   function automatic int gap_cnt_w(input int gap_cycles);
      return (gap_cycles < 1) ? 1 : $clog2(gap_cycles + 1);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request searching upward from ptr+1.
module rr_picker #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   always_comb begin
      int k;
      k      = 0;
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      // Walk offsets from farthest to nearest so the nearest hit wins.
      for (int off = N; off >= 1; off--) begin
         k = (int'(ptr) + off) % N;
         if (req[k]) begin
            onehot    = '0;
            onehot[k] = 1'b1;
            idx       = IDX_W'(k);
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master between N_REQ requesters.
// Optional ACTIVE-state timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
   import spi_arb_pkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int WR_W           = 24,
   parameter int RD_W           = 8,
   parameter int SEL_W          = 1,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WR_W-1:0]  req_wr_data,
   input  logic [N_REQ*SEL_W-1:0] req_sel,
   output logic [N_REQ-1:0]       req_ack,
   output logic [RD_W-1:0]        rd_data,
   output logic [N_REQ-1:0]       grant,
   output logic                   busy,
   output logic                   spi_req,
   output logic [WR_W-1:0]        spi_wr_data,
   output logic [SEL_W-1:0]       spi_sel,
   input  logic                   spi_ack,
   input  logic [RD_W-1:0]        spi_rd_data,
   output logic                   timeout_err
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int GAP_W = gap_cnt_w(GAP_CYCLES);
   localparam logic [GAP_W-1:0]    GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0]    PTR_INIT = IDX_W'(N_REQ - 1);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("spi_req_arbiter: N_REQ must be 2..8");
   end
   if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("spi_req_arbiter: GAP_CYCLES must be >= 1");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_to
      $error("spi_req_arbiter: TIMEOUT_CYCLES must be >= 1");
   end

   logic [WR_W-1:0]  wr_word [N_REQ];
   logic [SEL_W-1:0] sel_word [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign wr_word[gi]  = req_wr_data[gi*WR_W +: WR_W];
      assign sel_word[gi] = req_sel[gi*SEL_W +: SEL_W];
   end

   logic [N_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;

   arb_state_t       state_reg;
   logic [IDX_W-1:0] ptr_reg;
   logic [GAP_W-1:0] gap_cnt_reg;

   rr_picker #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req    (req),
      .ptr    (ptr_reg),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   assign busy = (state_reg != ST_IDLE);

`ifdef SPI_ARB_TIMEOUT_EN
   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
   logic [TO_CNT_W-1:0] to_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         ptr_reg     <= PTR_INIT;
         gap_cnt_reg <= '0;
         to_cnt_reg  <= '0;
         grant       <= '0;
         req_ack     <= '0;
         rd_data     <= '0;
         spi_req     <= 1'b0;
         spi_wr_data <= '0;
         spi_sel     <= '0;
         timeout_err <= 1'b0;
      end else begin
         req_ack <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant       <= pick_onehot;
                  ptr_reg     <= pick_idx;
                  spi_wr_data <= wr_word[pick_idx];
                  spi_sel     <= sel_word[pick_idx];
                  spi_req     <= 1'b1;
                  to_cnt_reg  <= '0;
                  state_reg   <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               // A genuine ack wins over a timeout landing on the same cycle.
               if (spi_ack) begin
                  rd_data     <= spi_rd_data;
                  spi_req     <= 1'b0;
                  req_ack     <= grant;
                  grant       <= '0;
                  gap_cnt_reg <= GAP_LOAD;
                  state_reg   <= ST_GAP;
               end else if (to_cnt_reg == TO_LAST) begin
                  rd_data     <= '0;
                  timeout_err <= 1'b1;
                  spi_req     <= 1'b0;
                  req_ack     <= grant;
                  grant       <= '0;
                  gap_cnt_reg <= GAP_LOAD;
                  state_reg   <= ST_GAP;
               end else begin
                  to_cnt_reg <= to_cnt_reg + 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt_reg == '0) begin
                  state_reg <= ST_IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end
`else
   assign timeout_err = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         ptr_reg     <= PTR_INIT;
         gap_cnt_reg <= '0;
         grant       <= '0;
         req_ack     <= '0;
         rd_data     <= '0;
         spi_req     <= 1'b0;
         spi_wr_data <= '0;
         spi_sel     <= '0;
      end else begin
         req_ack <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant       <= pick_onehot;
                  ptr_reg     <= pick_idx;
                  spi_wr_data <= wr_word[pick_idx];
                  spi_sel     <= sel_word[pick_idx];
                  spi_req     <= 1'b1;
                  state_reg   <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (spi_ack) begin
                  rd_data     <= spi_rd_data;
                  spi_req     <= 1'b0;
                  req_ack     <= grant;
                  grant       <= '0;
                  gap_cnt_reg <= GAP_LOAD;
                  state_reg   <= ST_GAP;
               end
            end
            ST_GAP: begin
               // Requests are deliberately not looked at here; IDLE re-samples them.
               if (gap_cnt_reg == '0) begin
                  state_reg <= ST_IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed, table-driven bench for spi_req_arbiter (N_REQ=2, GAP_CYCLES=4, TIMEOUT_CYCLES=100).
module tb_spi_req_arbiter;

   localparam int N   = 2;
   localparam int WR  = 24;
   localparam int RD  = 8;
   localparam int SEL = 1;
   localparam int GAP = 4;
   localparam int TO  = 100;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*WR-1:0] req_wr_data = '0;
   logic [N*SEL-1:0] req_sel = '0;
   logic [N-1:0]    req_ack;
   logic [RD-1:0]   rd_data;
   logic [N-1:0]    grant;
   logic            busy;
   logic            spi_req;
   logic [WR-1:0]   spi_wr_data;
   logic [SEL-1:0]  spi_sel;
   logic            spi_ack = 1'b0;
   logic [RD-1:0]   spi_rd_data = '0;
   logic            timeout_err;

   spi_req_arbiter #(
      .N_REQ          (N),
      .WR_W           (WR),
      .RD_W           (RD),
      .SEL_W          (SEL),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_wr_data (req_wr_data),
      .req_sel     (req_sel),
      .req_ack     (req_ack),
      .rd_data     (rd_data),
      .grant       (grant),
      .busy        (busy),
      .spi_req     (spi_req),
      .spi_wr_data (spi_wr_data),
      .spi_sel     (spi_sel),
      .spi_ack     (spi_ack),
      .spi_rd_data (spi_rd_data),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [RD-1:0] model_rd = '0;

   typedef struct {
      logic [1:0]  req;
      logic [23:0] wr0;
      logic [23:0] wr1;
      logic        sel0;
      logic        sel1;
      int          dly;
      logic [7:0]  rd;
      logic [1:0]  g;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge of the next IDLE cycle.
   task automatic run_txn(input int id, input vec_t v);
      logic [23:0] exp_wr;
      logic        exp_sel;
      int          bad;
      exp_wr  = (v.g == 2'b01) ? v.wr0 : v.wr1;
      exp_sel = (v.g == 2'b01) ? v.sel0 : v.sel1;
      req         = v.req;
      req_wr_data = {v.wr1, v.wr0};
      req_sel     = {v.sel1, v.sel0};
      @(negedge clk);
      chk($sformatf("v%0d spi_req rise", id), 32'(spi_req), 32'd1);
      chk($sformatf("v%0d grant", id), 32'(grant), 32'(v.g));
      chk($sformatf("v%0d spi_wr_data", id), 32'(spi_wr_data), 32'(exp_wr));
      chk($sformatf("v%0d spi_sel", id), 32'(spi_sel), 32'(exp_sel));
      chk($sformatf("v%0d rd_data held", id), 32'(rd_data), 32'(model_rd));
      req_wr_data = ~req_wr_data;
      req_sel     = ~req_sel;
      repeat (v.dly - 1) @(negedge clk);
      chk($sformatf("v%0d wr_data stable", id), 32'(spi_wr_data), 32'(exp_wr));
      spi_ack     = 1'b1;
      spi_rd_data = v.rd;
      @(negedge clk);
      spi_ack     = 1'b0;
      spi_rd_data = ~v.rd;
      req         = req & ~v.g;
      model_rd    = v.rd;
      chk($sformatf("v%0d req_ack", id), 32'(req_ack), 32'(v.g));
      chk($sformatf("v%0d rd_data", id), 32'(rd_data), 32'(v.rd));
      chk($sformatf("v%0d ack spi_req/grant/busy", id), {spi_req, grant, busy}, {1'b0, 2'b00, 1'b1});
      bad = 0;
      repeat (GAP - 1) begin
         @(negedge clk);
         if (spi_req !== 1'b0 || req_ack !== '0 || busy !== 1'b1) bad++;
      end
      chk($sformatf("v%0d gap quiet cycles", id), 32'(bad), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d idle busy/spi_req", id), {busy, spi_req}, 2'b00);
      $display("txn v%0d: req=%b grant=%b wr=0x%06h sel=%0d rd=0x%02h", id, v.req, v.g, exp_wr, exp_sel, v.rd);
   endtask

   initial begin
      int bad;
      vecs[0]  = '{2'b01, 24'h300ABC, 24'h111111, 1'b1, 1'b0, 20, 8'hA5, 2'b01};
      vecs[1]  = '{2'b11, 24'h0A0A0A, 24'h5B5B5B, 1'b0, 1'b1, 3,  8'h3C, 2'b10};
      vecs[2]  = '{2'b11, 24'h123456, 24'h654321, 1'b1, 1'b1, 1,  8'h00, 2'b01};
      vecs[3]  = '{2'b11, 24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 5,  8'hFF, 2'b10};
      vecs[4]  = '{2'b11, 24'h800000, 24'h7FFFFF, 1'b1, 1'b0, 2,  8'h81, 2'b01};
      vecs[5]  = '{2'b10, 24'h000000, 24'hABCDEF, 1'b0, 1'b1, 4,  8'h5A, 2'b10};
      vecs[6]  = '{2'b10, 24'h000000, 24'h00FF00, 1'b0, 1'b0, 2,  8'h96, 2'b10};
      vecs[7]  = '{2'b11, 24'hAAAAAA, 24'h555555, 1'b1, 1'b0, 3,  8'h11, 2'b01};
      vecs[8]  = '{2'b11, 24'hAAAAAA, 24'h555555, 1'b1, 1'b0, 3,  8'h22, 2'b10};
      vecs[9]  = '{2'b11, 24'hAAAAAA, 24'h555555, 1'b1, 1'b0, 6,  8'h44, 2'b01};
      vecs[10] = '{2'b11, 24'hAAAAAA, 24'h555555, 1'b1, 1'b0, 2,  8'h88, 2'b10};

      repeat (2) @(negedge clk);
      chk("reset outputs", {req_ack, rd_data, grant, busy, spi_req, timeout_err},
          {2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0});
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset spi_wr_data/sel", {spi_wr_data, spi_sel}, 25'd0);

      // Stray acks while idle must not produce a completion.
      spi_ack = 1'b1;
      spi_rd_data = 8'hEE;
      repeat (2) @(negedge clk);
      spi_ack = 1'b0;
      chk("idle stray ack", {req_ack, rd_data, busy}, {2'b00, 8'h00, 1'b0});

      for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

      // Asynchronous reset in the middle of an ACTIVE transfer.
      req = 2'b10;
      @(negedge clk);
      chk("pre-reset grant", {spi_req, grant}, {1'b1, 2'b10});
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async reset drop", {spi_req, grant, req_ack, busy, rd_data}, {1'b0, 2'b00, 2'b00, 1'b0, 8'h00});
      model_rd = '0;
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      $display("txn reset-in-active: outputs cleared");

      for (int i = 7; i < 11; i++) run_txn(i, vecs[i]);

      // Late release: requester 0 still requesting when IDLE is re-entered.
      req = 2'b01;
      req_wr_data = {24'h0, 24'hC0FFEE};
      req_sel = 2'b00;
      @(negedge clk);
      chk("late first grant", {spi_req, grant}, {1'b1, 2'b01});
      repeat (2) @(negedge clk);
      spi_ack = 1'b1;
      spi_rd_data = 8'h42;
      @(negedge clk);
      spi_ack = 1'b0;
      chk("late first ack", {req_ack, rd_data}, {2'b01, 8'h42});
      bad = 0;
      repeat (GAP - 1) begin
         @(negedge clk);
         if (spi_req !== 1'b0) bad++;
      end
      chk("late gap quiet", 32'(bad), 32'd0);
      @(negedge clk);
      chk("late idle", {busy, spi_req}, 2'b00);
      @(negedge clk);
      chk("late second grant", {spi_req, grant, spi_wr_data}, {1'b1, 2'b01, 24'hC0FFEE});
      req = 2'b00;
      spi_ack = 1'b1;
      spi_rd_data = 8'h17;
      @(negedge clk);
      spi_ack = 1'b0;
      chk("late second ack", {req_ack, rd_data}, {2'b01, 8'h17});
      model_rd = 8'h17;
      repeat (GAP) @(negedge clk);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (spi_req !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("dropped req no new txn", 32'(bad), 32'd0);
      $display("txn late-release: two grants to requester 0, then idle");

`ifdef SPI_ARB_TIMEOUT_EN
      req = 2'b01;
      @(negedge clk);
      chk("to spi_req rise", {spi_req, grant}, {1'b1, 2'b01});
      req = 2'b00;
      bad = 0;
      for (int k = 1; k < TO; k++) begin
         @(negedge clk);
         if (spi_req !== 1'b1 || req_ack !== '0 || timeout_err !== 1'b0) bad++;
      end
      chk("to waiting cycles", 32'(bad), 32'd0);
      @(negedge clk);
      chk("to abort", {req_ack, spi_req, rd_data, timeout_err}, {2'b01, 1'b0, 8'h00, 1'b1});
      repeat (GAP) @(negedge clk);
      chk("to sticky", {timeout_err, busy}, {1'b1, 1'b0});
      $display("txn timeout: aborted after %0d cycles", TO);
`else
      req = 2'b01;
      @(negedge clk);
      chk("no-to spi_req rise", {spi_req, grant}, {1'b1, 2'b01});
      req = 2'b00;
      bad = 0;
      repeat (150) begin
         @(negedge clk);
         if (spi_req !== 1'b1 || req_ack !== '0 || timeout_err !== 1'b0) bad++;
      end
      chk("no-to wait held", 32'(bad), 32'd0);
      spi_ack = 1'b1;
      spi_rd_data = 8'h33;
      @(negedge clk);
      spi_ack = 1'b0;
      chk("no-to late ack", {req_ack, rd_data, timeout_err}, {2'b01, 8'h33, 1'b0});
      repeat (GAP) @(negedge clk);
      $display("txn long-wait: no timeout, ack after 150 cycles");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
